video_in: RTL and testbench

- Avalon-ST Video sink. Accepts packetised video (sop/eop/valid/ready, header beat first) and emits a raw pixel stream with frame/line markers.
- Strips the packet-type header beat and drops non-video packets.
- Checks pixel count against the active frame size.
- Sits at the front of a processing pipeline, the opposite end of the link from the block that packetises raw pixels.

---
 rtl/video_in.sv | 267 ++++++++++++++++++++++++++
 tb/tb_video_in.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_in.sv
// video_in: Avalon-ST Video sink.
// Consumes packetised video (header beat first), strips the packet-type
// header, drops non-video packets and emits a raw pixel stream qualified
// with start-of-frame and end-of-line markers. The pixel count of each
// frame is checked against the active frame size, and a sticky error flag
// records any protocol violation.
// Optional feature macro: VIDEO_IN_CTRL_PARSE_EN. When it is defined,
// type 0xF control packets carry a new frame width/height that overrides
// the width/height inputs for later frames.

module video_in #(
   parameter int DATA_WIDTH = 24,
   parameter int DIM_WIDTH  = 16,
   parameter int FCNT_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] sink_data,
   input  logic                  sink_valid,
   input  logic                  sink_sop,
   input  logic                  sink_eop,
   output logic                  sink_ready,
   output logic [DATA_WIDTH-1:0] source_data,
   output logic                  source_valid,
   input  logic                  source_ready,
   output logic                  source_sof,
   output logic                  source_eol,
   input  logic [DIM_WIDTH-1:0]  width,
   input  logic [DIM_WIDTH-1:0]  height,
   input  logic                  err_clr,
   output logic [DIM_WIDTH-1:0]  act_width,
   output logic [DIM_WIDTH-1:0]  act_height,
   output logic                  pkt_error,
   output logic [FCNT_WIDTH-1:0] frame_cnt
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_VIDEO,
      S_DISCARD,
      S_CTRL
   } state_t;

   state_t state, state_nxt;

   logic                 accept;
   logic [3:0]           pkt_type;
   logic [DIM_WIDTH-1:0] cnt_x, cnt_y;
   logic                 last_x, last_y;
   logic                 size_held;
   logic [DIM_WIDTH-1:0] act_w_q, act_h_q;
   logic [DIM_WIDTH-1:0] hdr_w, hdr_h;

   logic fwd, fwd_sof, fwd_eol;
   logic set_err, frame_done, latch_hdr, adv_cnt;

`ifdef VIDEO_IN_CTRL_PARSE_EN
   logic                 ctrl_held;
   logic [1:0]           ctrl_beats;
   logic [DIM_WIDTH-1:0] pend_w, pend_h;
   logic                 ctrl_start, ctrl_store, ctrl_commit;
`endif

   // The output register can take a beat whenever it is empty or draining;
   // reset forces the sink closed.
   assign sink_ready = !rst && (!source_valid || source_ready);
   assign accept     = sink_valid && sink_ready;
   assign pkt_type   = sink_data[3:0];

   // Until the first header latches a size, the inputs are shown directly.
   assign act_width  = size_held ? act_w_q : width;
   assign act_height = size_held ? act_h_q : height;

`ifdef VIDEO_IN_CTRL_PARSE_EN
   // A committed control packet keeps its size ahead of the inputs.
   assign hdr_w = ctrl_held ? act_w_q : width;
   assign hdr_h = ctrl_held ? act_h_q : height;
`else
   assign hdr_w = width;
   assign hdr_h = height;
`endif

   assign last_x = (cnt_x == act_width - DIM_WIDTH'(1));
   assign last_y = (cnt_y == act_height - DIM_WIDTH'(1));

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode: header beats are handled the same in every state.
   always_comb begin
      state_nxt  = state;
      set_err    = 1'b0;
      frame_done = 1'b0;
      latch_hdr  = 1'b0;
      adv_cnt    = 1'b0;
      fwd        = 1'b0;
`ifdef VIDEO_IN_CTRL_PARSE_EN
      ctrl_start  = 1'b0;
      ctrl_store  = 1'b0;
      ctrl_commit = 1'b0;
`endif
      if (accept) begin
         if (sink_sop) begin
            if (state == S_VIDEO) set_err = 1'b1;
`ifdef VIDEO_IN_CTRL_PARSE_EN
            if (state == S_CTRL && ctrl_beats < 2'd2) set_err = 1'b1;
`endif
            if (pkt_type == 4'h0) begin
               latch_hdr = 1'b1;
               if (sink_eop) begin
                  set_err   = 1'b1;
                  state_nxt = S_IDLE;
               end else if (hdr_w == '0 || hdr_h == '0) begin
                  set_err   = 1'b1;
                  state_nxt = S_DISCARD;
               end else begin
                  state_nxt = S_VIDEO;
               end
            end
`ifdef VIDEO_IN_CTRL_PARSE_EN
            else if (pkt_type == 4'hF) begin
               if (sink_eop) begin
                  set_err   = 1'b1;
                  state_nxt = S_IDLE;
               end else begin
                  ctrl_start = 1'b1;
                  state_nxt  = S_CTRL;
               end
            end
`endif
            else begin
               state_nxt = sink_eop ? S_IDLE : S_DISCARD;
            end
         end else begin
            case (state)
               S_VIDEO: begin
                  fwd = 1'b1;
                  if (last_x && last_y) begin
                     if (sink_eop) begin
                        frame_done = 1'b1;
                        state_nxt  = S_IDLE;
                     end else begin
                        set_err   = 1'b1;
                        state_nxt = S_DISCARD;
                     end
                  end else if (sink_eop) begin
                     set_err   = 1'b1;
                     state_nxt = S_IDLE;
                  end else begin
                     adv_cnt = 1'b1;
                  end
               end
               S_DISCARD: begin
                  if (sink_eop) state_nxt = S_IDLE;
               end
`ifdef VIDEO_IN_CTRL_PARSE_EN
               S_CTRL: begin
                  ctrl_store = 1'b1;
                  if (sink_eop) begin
                     if (ctrl_beats != 2'd0) ctrl_commit = 1'b1;
                     else                    set_err     = 1'b1;
                     state_nxt = S_IDLE;
                  end
               end
`endif
               default: ;
            endcase
         end
      end
   end

   // Output decode: position markers for the pixel being forwarded.
   always_comb begin
      fwd_sof = (cnt_x == '0) && (cnt_y == '0);
      fwd_eol = last_x;
   end

   // One-entry output register; it only loads when it is free to.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         source_valid <= 1'b0;
         source_sof   <= 1'b0;
         source_eol   <= 1'b0;
         source_data  <= '0;
      end else if (sink_ready) begin
         source_valid <= fwd;
         source_sof   <= fwd && fwd_sof;
         source_eol   <= fwd && fwd_eol;
         if (fwd) source_data <= sink_data;
      end
   end

   // Pixel position within the frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_x <= '0;
         cnt_y <= '0;
      end else if (latch_hdr) begin
         cnt_x <= '0;
         cnt_y <= '0;
      end else if (adv_cnt) begin
         if (last_x) begin
            cnt_x <= '0;
            cnt_y <= cnt_y + DIM_WIDTH'(1);
         end else begin
            cnt_x <= cnt_x + DIM_WIDTH'(1);
         end
      end
   end

   // Sticky error flag and good-frame counter; a new error beats a clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pkt_error <= 1'b0;
         frame_cnt <= '0;
      end else begin
         if (set_err)      pkt_error <= 1'b1;
         else if (err_clr) pkt_error <= 1'b0;
         if (frame_done)   frame_cnt <= frame_cnt + FCNT_WIDTH'(1);
      end
   end

   // Active frame size, captured at each video header or control commit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         size_held <= 1'b0;
         act_w_q   <= '0;
         act_h_q   <= '0;
`ifdef VIDEO_IN_CTRL_PARSE_EN
         ctrl_held <= 1'b0;
`endif
      end else if (latch_hdr) begin
         size_held <= 1'b1;
         act_w_q   <= hdr_w;
         act_h_q   <= hdr_h;
      end
`ifdef VIDEO_IN_CTRL_PARSE_EN
      else if (ctrl_commit) begin
         size_held <= 1'b1;
         ctrl_held <= 1'b1;
         act_w_q   <= pend_w;
         act_h_q   <= (ctrl_beats == 2'd1) ? sink_data[DIM_WIDTH-1:0] : pend_h;
      end
`endif
   end

`ifdef VIDEO_IN_CTRL_PARSE_EN
   // Control payload capture: first beat is width, second is height.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_beats <= '0;
         pend_w     <= '0;
         pend_h     <= '0;
      end else if (ctrl_start) begin
         ctrl_beats <= '0;
      end else if (ctrl_store) begin
         if (ctrl_beats == 2'd0)      pend_w <= sink_data[DIM_WIDTH-1:0];
         else if (ctrl_beats == 2'd1) pend_h <= sink_data[DIM_WIDTH-1:0];
         if (ctrl_beats != 2'd2) ctrl_beats <= ctrl_beats + 2'd1;
      end
   end
`endif

endmodule

// File: tb/tb_video_in.sv
// tb_video_in: directed self-checking bench for video_in.
// Inputs change on the falling edge; the output monitor samples 3 ns later,
// which is what the next rising edge will see.

module tb_video_in;

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] sink_data;
   logic        sink_valid, sink_sop, sink_eop, sink_ready;
   logic [23:0] source_data;
   logic        source_valid, source_ready, source_sof, source_eol;
   logic [15:0] width, height;
   logic        err_clr;
   logic [15:0] act_width, act_height;
   logic        pkt_error;
   logic [15:0] frame_cnt;

   typedef struct {
      logic [23:0] d;
      logic        sof;
      logic        eol;
      int          cyc;
   } beat_t;

   beat_t outq[$];
   int    accq[$];
   int    compared   = 0;
   int    mismatched = 0;
   int    cyc        = 0;
   int    stalls     = 0;
   bit    toggle_rdy = 0;
   bit    prev_stall = 0;
   logic [23:0] prev_data = '0;

   video_in #(.DATA_WIDTH(24), .DIM_WIDTH(16), .FCNT_WIDTH(16)) dut (
      .clk(clk), .rst(rst),
      .sink_data(sink_data), .sink_valid(sink_valid), .sink_sop(sink_sop),
      .sink_eop(sink_eop), .sink_ready(sink_ready),
      .source_data(source_data), .source_valid(source_valid),
      .source_ready(source_ready), .source_sof(source_sof), .source_eol(source_eol),
      .width(width), .height(height), .err_clr(err_clr),
      .act_width(act_width), .act_height(act_height),
      .pkt_error(pkt_error), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   // Output monitor: collects transferred pixels and checks stall stability.
   always begin
      @(negedge clk);
      #3;
      if (prev_stall) begin
         compared++;
         if (source_valid !== 1'b1 || source_data !== prev_data) begin
            mismatched++;
            $display("[TB] FAIL hold got valid=%b data=%h want valid=1 data=%h",
                     source_valid, source_data, prev_data);
         end
      end
      if (source_valid === 1'b1 && source_ready === 1'b1)
         outq.push_back('{d: source_data, sof: source_sof, eol: source_eol, cyc: cyc});
      prev_stall = (source_valid === 1'b1) && (source_ready === 1'b0);
      prev_data  = source_data;
   end

   function automatic beat_t mk(input logic [23:0] d, input logic sof, input logic eol);
      mk = '{d: d, sof: sof, eol: eol, cyc: 0};
   endfunction

   // Present one beat and hold it until accepted (bounded).
   task automatic send_beat(input logic [23:0] d, input logic sop, input logic eop);
      bit ok;
      int n;
      n = 0;
      sink_data  = d;
      sink_sop   = sop;
      sink_eop   = eop;
      sink_valid = 1'b1;
      forever begin
         if (toggle_rdy) source_ready = ~source_ready;
         #1;
         ok = sink_ready;
         @(negedge clk);
         if (ok) break;
         stalls++;
         n++;
         if (n > 100) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL accept_timeout got no accept want accept within 100 cycles");
            break;
         end
      end
      if (!sop) accq.push_back(cyc);
      sink_valid = 1'b0;
      sink_sop   = 1'b0;
      sink_eop   = 1'b0;
   endtask

   task automatic idle(input int n);
      sink_valid   = 1'b0;
      sink_sop     = 1'b0;
      sink_eop     = 1'b0;
      toggle_rdy   = 0;
      source_ready = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame8(input logic [23:0] base);
      send_beat(24'h0, 1'b1, 1'b0);
      for (int i = 1; i <= 8; i++) send_beat(base + 24'(i), 1'b0, i == 8);
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      compared++;
      if (sink_ready !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_ready got %b want 0", sink_ready);
      end
      compared++;
      if ({source_valid, source_sof, source_eol, source_data, pkt_error, frame_cnt} !== 44'h0) begin
         mismatched++;
         $display("[TB] FAIL reset_outputs got v=%b sof=%b eol=%b d=%h err=%b fc=%0d want zeros",
                  source_valid, source_sof, source_eol, source_data, pkt_error, frame_cnt);
      end
      compared++;
      if (act_width !== 16'd4 || act_height !== 16'd2) begin
         mismatched++;
         $display("[TB] FAIL reset_size got %0dx%0d want 4x2", act_width, act_height);
      end
      rst = 1'b0;
      #1;
      compared++;
      if (sink_ready !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL release_ready got %b want 1", sink_ready);
      end
      @(negedge clk);
   endtask

   task automatic test_basic_frame();
      beat_t exp[$];
      outq.delete();
      accq.delete();
      send_frame8(24'h0);
      idle(4);
      for (int i = 1; i <= 8; i++) exp.push_back(mk(24'(i), i == 1, (i % 4) == 0));
      compared++;
      if (outq.size() !== exp.size()) begin
         mismatched++;
         $display("[TB] FAIL basic_count got %0d want %0d", outq.size(), exp.size());
      end
      foreach (exp[i]) if (i < outq.size()) begin
         compared++;
         if ({outq[i].d, outq[i].sof, outq[i].eol} !== {exp[i].d, exp[i].sof, exp[i].eol}) begin
            mismatched++;
            $display("[TB] FAIL basic_pix%0d got d=%h sof=%b eol=%b want d=%h sof=%b eol=%b",
                     i, outq[i].d, outq[i].sof, outq[i].eol, exp[i].d, exp[i].sof, exp[i].eol);
         end
         compared++;
         if (outq[i].cyc !== accq[i]) begin
            mismatched++;
            $display("[TB] FAIL basic_latency%0d got cycle %0d want cycle %0d", i, outq[i].cyc, accq[i]);
         end
      end
      compared++;
      if (frame_cnt !== 16'd1 || pkt_error !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL basic_status got fc=%0d err=%b want fc=1 err=0", frame_cnt, pkt_error);
      end
   endtask

   task automatic test_backpressure();
      beat_t exp[$];
      outq.delete();
      stalls     = 0;
      source_ready = 1'b0;
      toggle_rdy = 1;
      send_frame8(24'h0);
      idle(6);
      for (int i = 1; i <= 8; i++) exp.push_back(mk(24'(i), i == 1, (i % 4) == 0));
      compared++;
      if (stalls == 0) begin
         mismatched++;
         $display("[TB] FAIL bp_throttle got 0 stall cycles want >0");
      end
      compared++;
      if (outq.size() !== exp.size()) begin
         mismatched++;
         $display("[TB] FAIL bp_count got %0d want %0d", outq.size(), exp.size());
      end
      foreach (exp[i]) if (i < outq.size()) begin
         compared++;
         if ({outq[i].d, outq[i].sof, outq[i].eol} !== {exp[i].d, exp[i].sof, exp[i].eol}) begin
            mismatched++;
            $display("[TB] FAIL bp_pix%0d got d=%h sof=%b eol=%b want d=%h sof=%b eol=%b",
                     i, outq[i].d, outq[i].sof, outq[i].eol, exp[i].d, exp[i].sof, exp[i].eol);
         end
      end
      compared++;
      if (frame_cnt !== 16'd2 || pkt_error !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL bp_status got fc=%0d err=%b want fc=2 err=0", frame_cnt, pkt_error);
      end
   endtask

   task automatic test_short_frame();
      beat_t exp[$];
      outq.delete();
      send_beat(24'h0, 1'b1, 1'b0);
      for (int i = 1; i <= 5; i++) send_beat(24'(i), 1'b0, i == 5);
      idle(4);
      for (int i = 1; i <= 5; i++) exp.push_back(mk(24'(i), i == 1, i == 4));
      compared++;
      if (outq.size() !== exp.size()) begin
         mismatched++;
         $display("[TB] FAIL short_count got %0d want %0d", outq.size(), exp.size());
      end
      foreach (exp[i]) if (i < outq.size()) begin
         compared++;
         if ({outq[i].d, outq[i].sof, outq[i].eol} !== {exp[i].d, exp[i].sof, exp[i].eol}) begin
            mismatched++;
            $display("[TB] FAIL short_pix%0d got d=%h sof=%b eol=%b want d=%h sof=%b eol=%b",
                     i, outq[i].d, outq[i].sof, outq[i].eol, exp[i].d, exp[i].sof, exp[i].eol);
         end
      end
      compared++;
      if (frame_cnt !== 16'd2 || pkt_error !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL short_status got fc=%0d err=%b want fc=2 err=1", frame_cnt, pkt_error);
      end
      pulse_clr();
      compared++;
      if (pkt_error !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL err_clr got %b want 0", pkt_error);
      end
   endtask

   task automatic test_sop_mid_frame();
      beat_t exp[$];
      outq.delete();
      send_beat(24'h0, 1'b1, 1'b0);
      send_beat(24'd1, 1'b0, 1'b0);
      send_beat(24'd2, 1'b0, 1'b0);
      send_frame8(24'd10);
      idle(4);
      exp.push_back(mk(24'd1, 1'b1, 1'b0));
      exp.push_back(mk(24'd2, 1'b0, 1'b0));
      for (int i = 1; i <= 8; i++) exp.push_back(mk(24'(10 + i), i == 1, (i % 4) == 0));
      compared++;
      if (outq.size() !== exp.size()) begin
         mismatched++;
         $display("[TB] FAIL sopmid_count got %0d want %0d", outq.size(), exp.size());
      end
      foreach (exp[i]) if (i < outq.size()) begin
         compared++;
         if ({outq[i].d, outq[i].sof, outq[i].eol} !== {exp[i].d, exp[i].sof, exp[i].eol}) begin
            mismatched++;
            $display("[TB] FAIL sopmid_pix%0d got d=%h sof=%b eol=%b want d=%h sof=%b eol=%b",
                     i, outq[i].d, outq[i].sof, outq[i].eol, exp[i].d, exp[i].sof, exp[i].eol);
         end
      end
      compared++;
      if (frame_cnt !== 16'd3 || pkt_error !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL sopmid_status got fc=%0d err=%b want fc=3 err=1", frame_cnt, pkt_error);
      end
      pulse_clr();
   endtask

   task automatic test_discard();
      beat_t exp[$];
      outq.delete();
      send_beat(24'h3, 1'b1, 1'b0);
      for (int i = 1; i <= 6; i++) send_beat(24'(100 + i), 1'b0, i == 6);
      send_frame8(24'h0);
      idle(4);
      for (int i = 1; i <= 8; i++) exp.push_back(mk(24'(i), i == 1, (i % 4) == 0));
      compared++;
      if (outq.size() !== exp.size()) begin
         mismatched++;
         $display("[TB] FAIL discard_count got %0d want %0d", outq.size(), exp.size());
      end
      foreach (exp[i]) if (i < outq.size()) begin
         compared++;
         if ({outq[i].d, outq[i].sof, outq[i].eol} !== {exp[i].d, exp[i].sof, exp[i].eol}) begin
            mismatched++;
            $display("[TB] FAIL discard_pix%0d got d=%h sof=%b eol=%b want d=%h sof=%b eol=%b",
                     i, outq[i].d, outq[i].sof, outq[i].eol, exp[i].d, exp[i].sof, exp[i].eol);
         end
      end
      compared++;
      if (frame_cnt !== 16'd4 || pkt_error !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL discard_status got fc=%0d err=%b want fc=4 err=0", frame_cnt, pkt_error);
      end
   endtask

   task automatic test_zero_size();
      outq.delete();
      width = 16'd0;
      send_beat(24'h0, 1'b1, 1'b0);
      send_beat(24'd1, 1'b0, 1'b0);
      send_beat(24'd2, 1'b0, 1'b1);
      idle(4);
      width = 16'd4;
      compared++;
      if (outq.size() !== 0 || pkt_error !== 1'b1 || frame_cnt !== 16'd4) begin
         mismatched++;
         $display("[TB] FAIL zero_size got out=%0d err=%b fc=%0d want out=0 err=1 fc=4",
                  outq.size(), pkt_error, frame_cnt);
      end
      pulse_clr();
   endtask

   task automatic test_empty_frame();
      outq.delete();
      send_beat(24'h0, 1'b1, 1'b1);
      idle(3);
      compared++;
      if (outq.size() !== 0 || pkt_error !== 1'b1 || frame_cnt !== 16'd4) begin
         mismatched++;
         $display("[TB] FAIL empty_frame got out=%0d err=%b fc=%0d want out=0 err=1 fc=4",
                  outq.size(), pkt_error, frame_cnt);
      end
      pulse_clr();
   endtask

   task automatic test_ctrl();
      beat_t exp[$];
      outq.delete();
      send_beat(24'h00000F, 1'b1, 1'b0);
      send_beat(24'd2, 1'b0, 1'b0);
      send_beat(24'd3, 1'b0, 1'b1);
      send_beat(24'h0, 1'b1, 1'b0);
      for (int i = 1; i <= 6; i++) send_beat(24'(i), 1'b0, i == 6);
      idle(4);
`ifdef VIDEO_IN_CTRL_PARSE_EN
      for (int i = 1; i <= 6; i++) exp.push_back(mk(24'(i), i == 1, (i % 2) == 0));
      compared++;
      if (act_width !== 16'd2 || act_height !== 16'd3) begin
         mismatched++;
         $display("[TB] FAIL ctrl_size got %0dx%0d want 2x3", act_width, act_height);
      end
      compared++;
      if (frame_cnt !== 16'd5 || pkt_error !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL ctrl_status got fc=%0d err=%b want fc=5 err=0", frame_cnt, pkt_error);
      end
`else
      for (int i = 1; i <= 6; i++) exp.push_back(mk(24'(i), i == 1, i == 4));
      compared++;
      if (act_width !== 16'd4 || act_height !== 16'd2) begin
         mismatched++;
         $display("[TB] FAIL ctrl_size got %0dx%0d want 4x2", act_width, act_height);
      end
      compared++;
      if (frame_cnt !== 16'd4 || pkt_error !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL ctrl_status got fc=%0d err=%b want fc=4 err=1", frame_cnt, pkt_error);
      end
`endif
      compared++;
      if (outq.size() !== exp.size()) begin
         mismatched++;
         $display("[TB] FAIL ctrl_count got %0d want %0d", outq.size(), exp.size());
      end
      foreach (exp[i]) if (i < outq.size()) begin
         compared++;
         if ({outq[i].d, outq[i].sof, outq[i].eol} !== {exp[i].d, exp[i].sof, exp[i].eol}) begin
            mismatched++;
            $display("[TB] FAIL ctrl_pix%0d got d=%h sof=%b eol=%b want d=%h sof=%b eol=%b",
                     i, outq[i].d, outq[i].sof, outq[i].eol, exp[i].d, exp[i].sof, exp[i].eol);
         end
      end
      pulse_clr();
   endtask

   task automatic test_reset_mid_packet();
      send_beat(24'h0, 1'b1, 1'b0);
      send_beat(24'd1, 1'b0, 1'b0);
      send_beat(24'd2, 1'b0, 1'b0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      outq.delete();
      for (int i = 3; i <= 8; i++) send_beat(24'(i), 1'b0, i == 8);
      idle(4);
      compared++;
      if (outq.size() !== 0) begin
         mismatched++;
         $display("[TB] FAIL rstmid_out got %0d pixels want 0", outq.size());
      end
      compared++;
      if (act_width !== 16'd4 || act_height !== 16'd2 || frame_cnt !== 16'd0 || pkt_error !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL rstmid_status got %0dx%0d fc=%0d err=%b want 4x2 fc=0 err=0",
                  act_width, act_height, frame_cnt, pkt_error);
      end
   endtask

   initial begin
      rst          = 1'b1;
      sink_data    = '0;
      sink_valid   = 1'b0;
      sink_sop     = 1'b0;
      sink_eop     = 1'b0;
      source_ready = 1'b1;
      width        = 16'd4;
      height       = 16'd2;
      err_clr      = 1'b0;
      $display("[TB] video_in directed bench start");
      test_reset();
      test_basic_frame();
      test_backpressure();
      test_short_frame();
      test_sop_mid_frame();
      test_discard();
      test_zero_size();
      test_empty_frame();
      test_ctrl();
      test_reset_mid_packet();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
